mult_4x4_rom_sequencer: RTL and testbench
=========================================

Name: mult_4x4_rom_sequencer

Overview:
- Controller that walks the 32x4 operand ROM: multiplicand i at address i, multiplier i at address i+PAIR_OFFSET.
- For each pair, runs a 4-cycle shift-add multiply (ASM datapath) and presents the 8-bit product on a valid/ready output handshake.
- Sits between the combinational operand ROM and the display/checker logic in the lab multiplier design.

Parameters:
- N_PAIRS, 16, number of operand pairs processed per run (legal 1..16).
- PAIR_OFFSET, 16, ROM address offset of the multiplier bank.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request; sampled only in IDLE.
- rom_addr  output  5  operand ROM address.
- rom_data  input  4  operand ROM data; combinational, valid in the same cycle as rom_addr.
- product  output  8  multiplicand*multiplier of current pair.
- prod_valid  output  1  product is valid.
- prod_ready  input  1  consumer accepts the product.
- pair_idx  output  4  index of current pair.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - rom_addr=0, product=0, prod_valid=0, pair_idx=0, busy=0, done=0.
  - Internal A, B, acc and cnt cleared.
  - Reset mid-run aborts immediately and emits no partial product.
- FSM states: IDLE, FETCH_A, FETCH_B, MULT, OUT, DONE.
- IDLE: rom_addr=0. If start=1, go to FETCH_A with pair_idx=0.
- FETCH_A: rom_addr=pair_idx. Latch A<=rom_data. Go to FETCH_B.
- FETCH_B: rom_addr=pair_idx+PAIR_OFFSET (5-bit). Latch B<=rom_data, acc<=0, cnt<=0. Go to MULT.
- MULT:
  - Each cycle: if B[cnt]=1 then acc<=acc+(A<<cnt), with the sum computed 8 bits wide and no overflow possible (max 15*15=225).
  - cnt increments each cycle. After the cycle with cnt=3, go to OUT.
  - Exactly 4 cycles.
- OUT: prod_valid=1 and product=acc, both held stable until prod_ready=1.
  - On the cycle where prod_valid and prod_ready are both 1: if pair_idx==N_PAIRS-1, go to DONE; else pair_idx++ and go to FETCH_A.
  - prod_ready is ignored outside OUT.
- DONE: done=1 for exactly one cycle. pair_idx holds its last value. Go to IDLE.
- Latency: start sampled at edge E0 gives prod_valid=1 after edge E6 (6 cycles). Per-pair throughput is 7 cycles with prod_ready held high.
- start while busy: ignored, no restart.
- start=1 in the IDLE cycle directly after DONE: starts a new run.
- product: holds its last value outside OUT. It is updated only on entry to OUT.
- rom_addr in MULT, OUT and DONE: holds pair_idx+PAIR_OFFSET.

Optional Feature:
- Macro: MULT_SEQ_ZERO_SKIP_EN.
- Defined: in FETCH_B, if A==0 or rom_data==0, set acc<=0 and go straight to OUT, skipping MULT. prod_valid then rises 2 cycles after the FETCH_A edge instead of 6.
- Not defined: MULT always takes 4 cycles, and timing is data-independent.

Decomposition:
- Shared package mult_pkg holds:
  - state enum (IDLE..DONE, 3-bit encoding);
  - OPERAND_W=4, PRODUCT_W=8, ADDR_W=5;
  - MULT_CYCLES=4.
- One sub-module, mult_4x4_shift_add_dp: the A/B/acc/cnt registers with clear/load/step controls, driven by the FSM in the top module.

Test Plan:
1. ROM loaded with mcand[i]=i, mplier[i]=i, prod_ready tied 1, pulse start → 16 products 0,1,4,9,...,196,225 in order, consecutive valids 7 cycles apart, done pulses once 1 cycle after the last handshake, busy falls with it.
2. Backpressure: prod_ready=0 for 10 cycles on pair 5 → prod_valid stays 1 with product=25 stable, pair_idx=5, no advance; raising ready gives pair 6 valid 7 cycles later.
3. start pulsed at pair 3 during MULT → ignored; run completes all 16 products unchanged.
4. rst_n low during MULT of pair 7 → all outputs 0 immediately; after release plus start, the run restarts from pair 0 with product 0.
5. N_PAIRS=1 → single product 0, done asserted the cycle after the handshake, then IDLE.
6. With MULT_SEQ_ZERO_SKIP_EN: pair 0 valid 2 cycles after the FETCH_A edge (product 0); pair 1 still 6 cycles (product 1). Without the macro: pair 0 takes 6 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the 4x4 ROM-driven shift-add multiplier
// sequencer. The sequencer FSM state encoding lives here so the datapath,
// the top level and any external monitor agree on it.
package mult_pkg;

  localparam int OPERAND_W   = 4;
  localparam int PRODUCT_W   = 8;
  localparam int ADDR_W      = 5;
  localparam int PAIR_W      = 4;
  localparam int MULT_CYCLES = 4;
  localparam int CNT_W       = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    MULT    = 3'd3,
    OUT     = 3'd4,
    DONE    = 3'd5
  } state_e;

endpackage

// File: rtl/mult_4x4_shift_add_dp.sv
// Shift-add multiply datapath: holds multiplicand A, multiplier B, the
// partial-product accumulator and the bit counter. The sequencer FSM drives
// load/step strobes; acc_next_o exposes the value acc will take at the next
// edge so the top level can capture a finished product on OUT entry.
module mult_4x4_shift_add_dp
  import mult_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_a_i,
  input  logic                 load_b_i,
  input  logic                 step_i,
  input  logic [OPERAND_W-1:0] data_i,
  output logic                 a_zero_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic [PRODUCT_W-1:0] acc_next_o
);

  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic [PRODUCT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // Next-state for operand registers, accumulator and bit counter.
  // Loading B also clears acc/cnt so a fresh multiply starts from zero.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_a_i) begin
      a_d = data_i;
    end
    if (load_b_i) begin
      b_d   = data_i;
      acc_d = '0;
      cnt_d = '0;
    end else if (step_i) begin
      // 15*15 = 225 fits in 8 bits, so the sum never overflows.
      if (b_q[cnt_q]) begin
        acc_d = acc_q + (PRODUCT_W'(a_q) << cnt_q);
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign a_zero_o   = (a_q == '0);
  assign cnt_o      = cnt_q;
  assign acc_next_o = acc_d;

endmodule

// File: rtl/mult_4x4_rom_sequencer.sv
// Sequencer that walks the operand ROM pair by pair (multiplicand at
// address i, multiplier at i+PAIR_OFFSET), multiplies each pair with the
// shift-add datapath and offers the product on a valid/ready port.
// Optional build macro: MULT_SEQ_ZERO_SKIP_EN -- when defined, a pair with a
// zero operand bypasses the 4 MULT cycles and goes straight to OUT.
//
// Handshake: prod_valid is high in OUT with product stable; the product is
// consumed on the rising edge where prod_valid and prod_ready are both 1.
// prod_ready is ignored in every other state.
module mult_4x4_rom_sequencer
  import mult_pkg::*;
#(
  parameter int N_PAIRS     = 16,
  parameter int PAIR_OFFSET = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [ADDR_W-1:0]    rom_addr,
  input  logic [OPERAND_W-1:0] rom_data,
  output logic [PRODUCT_W-1:0] product,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic [PAIR_W-1:0]    pair_idx,
  output logic                 busy,
  output logic                 done,
  output state_e               dbg_state
);

`ifdef MULT_SEQ_ZERO_SKIP_EN
  localparam bit ZERO_SKIP_EN = 1'b1;
`else
  localparam bit ZERO_SKIP_EN = 1'b0;
`endif

  localparam logic [PAIR_W-1:0] LAST_PAIR  = PAIR_W'(N_PAIRS - 1);
  localparam logic [ADDR_W-1:0] B_BANK_OFS = ADDR_W'(PAIR_OFFSET);
  localparam logic [CNT_W-1:0]  LAST_STEP  = CNT_W'(MULT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [PAIR_W-1:0]      pair_idx_q, pair_idx_d;
  logic [PRODUCT_W-1:0]   product_q, product_d;

  logic                   load_a, load_b, step;
  logic                   a_zero;
  logic                   zero_skip;
  logic [CNT_W-1:0]       cnt;
  logic [PRODUCT_W-1:0]   acc_next;

  mult_4x4_shift_add_dp u_dp (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_a_i   (load_a),
    .load_b_i   (load_b),
    .step_i     (step),
    .data_i     (rom_data),
    .a_zero_o   (a_zero),
    .cnt_o      (cnt),
    .acc_next_o (acc_next)
  );

  // A zero operand makes the product zero; only taken when the feature is built in.
  assign zero_skip = ZERO_SKIP_EN && (a_zero || (rom_data == '0));

  // Next-state, pair index, datapath strobes and product capture.
  always_comb begin
    state_d    = state_q;
    pair_idx_d = pair_idx_q;
    product_d  = product_q;
    load_a     = 1'b0;
    load_b     = 1'b0;
    step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pair_idx_d = '0;
          state_d    = FETCH_A;
        end
      end
      FETCH_A: begin
        load_a  = 1'b1;
        state_d = FETCH_B;
      end
      FETCH_B: begin
        load_b  = 1'b1;
        state_d = zero_skip ? OUT : MULT;
      end
      MULT: begin
        step = 1'b1;
        if (cnt == LAST_STEP) begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (prod_ready) begin
          if (pair_idx_q == LAST_PAIR) begin
            state_d = DONE;
          end else begin
            pair_idx_d = pair_idx_q + 1'b1;
            state_d    = FETCH_A;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // The product register changes only when OUT is entered.
    if ((state_d == OUT) && (state_q != OUT)) begin
      product_d = acc_next;
    end
  end

  // Control registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pair_idx_q <= '0;
      product_q  <= '0;
    end else begin
      state_q    <= state_d;
      pair_idx_q <= pair_idx_d;
      product_q  <= product_d;
    end
  end

  // ROM address: multiplicand bank in FETCH_A, multiplier bank from FETCH_B on.
  always_comb begin
    rom_addr = ADDR_W'(pair_idx_q) + B_BANK_OFS;
    case (state_q)
      IDLE:    rom_addr = '0;
      FETCH_A: rom_addr = ADDR_W'(pair_idx_q);
      default: rom_addr = ADDR_W'(pair_idx_q) + B_BANK_OFS;
    endcase
  end

  assign product    = product_q;
  assign prod_valid = (state_q == OUT);
  assign pair_idx   = pair_idx_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mult_4x4_rom_sequencer.sv
// Bench for mult_4x4_rom_sequencer: a ROM model feeds the sequencer, operand
// tables set the expected products, and a negedge monitor compares every
// offered product against the expected queue.
module tb_mult_4x4_rom_sequencer;
  import mult_pkg::*;

  typedef struct {
    logic [3:0] mcand;
    logic [3:0] mplier;
    logic [7:0] exp_prod;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] rom [32];

  logic       start, prod_ready, prod_valid, busy, done;
  logic [4:0] rom_addr;
  logic [3:0] rom_data, pair_idx;
  logic [7:0] product;
  state_e     dbg_state;

  logic       start1, prod_ready1, prod_valid1, busy1, done1;
  logic [4:0] rom_addr1;
  logic [3:0] rom_data1, pair_idx1;
  logic [7:0] product1;
  state_e     dbg_state1;

  assign rom_data  = rom[rom_addr];
  assign rom_data1 = rom[rom_addr1];

  mult_4x4_rom_sequencer #(.N_PAIRS(16), .PAIR_OFFSET(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .product(product), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .pair_idx(pair_idx), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  mult_4x4_rom_sequencer #(.N_PAIRS(1), .PAIR_OFFSET(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rom_addr(rom_addr1),
    .rom_data(rom_data1), .product(product1), .prod_valid(prod_valid1),
    .prod_ready(prod_ready1), .pair_idx(pair_idx1), .busy(busy1),
    .done(done1), .dbg_state(dbg_state1)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];
  int rise_edge[16];
  int hs_edge[16];
  int hs_cnt;
  int done_cnt;
  bit prev_valid = 1'b0;
  vec_t sq_vecs[16];
  vec_t rnd_vecs[16];

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected cycles from the FETCH_A edge of pair i to its valid edge.
  function automatic int lat(input int i);
`ifdef MULT_SEQ_ZERO_SKIP_EN
    if (rom[i] == 4'd0 || rom[i+16] == 4'd0) return 2;
`endif
    return 6;
  endfunction

  // Monitor: sampled mid-cycle; a handshake takes effect on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (prod_valid) begin
        if (!prev_valid) rise_edge[pair_idx] = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_product", int'({pair_idx, product}), -1);
        end else begin
          check_eq("pair_product", int'({pair_idx, product}), int'(exp_q[0]));
          if (prod_ready) begin
            hs_edge[pair_idx] = cyc + 1;
            hs_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_valid = prod_valid;
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_table(input bit use_rnd);
    vec_t v;
    for (int i = 0; i < 16; i++) begin
      v = use_rnd ? rnd_vecs[i] : sq_vecs[i];
      rom[i]    = v.mcand;
      rom[i+16] = v.mplier;
      exp_q.push_back({4'(i), v.exp_prod});
    end
  endtask

  // mode: 0 plain, 1 backpressure on pair 5, 2 start during MULT of pair 3,
  // 3 reset during MULT of pair 7, 4 random prod_ready.
  task automatic run_pairs(input int mode);
    bit got = 1'b0;
    bit inj = 1'b0;
    int start_edge;
    hs_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      rise_edge[i] = -1;
      hs_edge[i] = -1;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    start_edge = cyc;
    check_eq("busy_after_start", int'(busy), 1);
    for (int n = 0; n < 800 && !got; n++) begin
      tick();
      if (done) begin
        got = 1'b1;
      end else begin
        case (mode)
          1: if (!inj && pair_idx == 4'd5 && prod_valid) begin
            prod_ready = 1'b0;
            for (int k = 0; k < 10; k++) begin
              tick();
              check_eq("bp_valid", int'(prod_valid), 1);
              check_eq("bp_product", int'(product), 25);
              check_eq("bp_pair_idx", int'(pair_idx), 5);
            end
            prod_ready = 1'b1;
            inj = 1'b1;
          end
          2: if (!inj && pair_idx == 4'd3 && dbg_state == MULT) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            inj = 1'b1;
            check_eq("restart_ignored_pair", int'(pair_idx), 3);
            check_eq("restart_ignored_busy", int'(busy), 1);
          end
          3: if (pair_idx == 4'd7 && dbg_state == MULT) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_rom_addr", int'(rom_addr), 0);
            check_eq("rst_product", int'(product), 0);
            check_eq("rst_valid", int'(prod_valid), 0);
            check_eq("rst_pair_idx", int'(pair_idx), 0);
            check_eq("rst_busy", int'(busy), 0);
            check_eq("rst_done", int'(done), 0);
            exp_q.delete();
            tick();
            tick();
            check_eq("rst_no_product", int'(prod_valid), 0);
            rst_n = 1'b1;
            return;
          end
          4: prod_ready = 1'($urandom_range(0, 1));
          default: ;
        endcase
      end
    end
    prod_ready = 1'b1;
    check_eq("run_timeout_done_seen", int'(got), 1);
    if (!got) return;
    check_eq("done_after_last_hs", cyc, hs_edge[15]);
    check_eq("handshake_count", hs_cnt, 16);
    check_eq("exp_q_drained", exp_q.size(), 0);
    check_eq("first_latency", rise_edge[0], start_edge + lat(0));
    for (int i = 1; i < 16; i++) begin
      check_eq($sformatf("pair%0d_latency", i), rise_edge[i], hs_edge[i-1] + lat(i));
    end
    if (mode == 1) check_eq("bp_hold_cycles", hs_edge[5] - rise_edge[5], 11);
    tick();
    check_eq("done_one_cycle", int'(done), 0);
    check_eq("busy_falls", int'(busy), 0);
    check_eq("done_pulse_count", done_cnt, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int se;
    bit seen;
    int a, b;
    for (int i = 0; i < 16; i++) begin
      sq_vecs[i] = '{mcand: 4'(i), mplier: 4'(i), exp_prod: 8'(i * i)};
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      if (i == 2) a = 0;
      if (i == 9) b = 0;
      if (i == 15) begin a = 15; b = 15; end
      rnd_vecs[i] = '{mcand: 4'(a), mplier: 4'(b), exp_prod: 8'(a * b)};
    end
    for (int i = 0; i < 32; i++) rom[i] = 4'd0;
    rst_n = 1'b0;
    start = 1'b0;
    prod_ready = 1'b1;
    start1 = 1'b0;
    prod_ready1 = 1'b1;
    tick();
    tick();
    check_eq("reset_rom_addr", int'(rom_addr), 0);
    check_eq("reset_product", int'(product), 0);
    check_eq("reset_valid", int'(prod_valid), 0);
    check_eq("reset_pair_idx", int'(pair_idx), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    check_eq("reset_state", int'(dbg_state), int'(IDLE));
    rst_n = 1'b1;
    tick();

    apply_table(1'b0);
    run_pairs(0);
    apply_table(1'b0);
    run_pairs(1);
    apply_table(1'b0);
    run_pairs(2);
    apply_table(1'b1);
    run_pairs(4);
    apply_table(1'b1);
    run_pairs(0);

    apply_table(1'b0);
    run_pairs(3);
    tick();
    check_eq("post_reset_idle", int'(busy), 0);
    apply_table(1'b0);
    run_pairs(0);

    // Single-pair instance: both operand combinations exercise lat().
    for (int t = 0; t < 2; t++) begin
      rom[0]  = (t == 0) ? 4'd0 : 4'd7;
      rom[16] = (t == 0) ? 4'd0 : 4'd9;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      se = cyc;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        tick();
        if (prod_valid1) seen = 1'b1;
      end
      check_eq("np1_valid_seen", int'(seen), 1);
      check_eq("np1_latency", cyc - se, lat(0));
      check_eq("np1_product", int'(product1), (t == 0) ? 0 : 63);
      check_eq("np1_pair_idx", int'(pair_idx1), 0);
      tick();
      check_eq("np1_done", int'(done1), 1);
      check_eq("np1_valid_drop", int'(prod_valid1), 0);
      tick();
      check_eq("np1_done_drop", int'(done1), 0);
      check_eq("np1_idle", int'(dbg_state1), int'(IDLE));
      check_eq("np1_product_held", int'(product1), (t == 0) ? 0 : 63);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
